// File: rtl/noc_out_arbiter.sv
// noc_out_arbiter: packet-granular round-robin arbiter driving one registered flit channel.
// Define NOC_ARB_WATCHDOG_EN to build the lock watchdog (LOCK_TIMEOUT cycles) and timeout_err.
module noc_out_arbiter #(
    parameter int NUM_IN       = 4,
    parameter int W            = 9,
    parameter int LOCK_TIMEOUT = 64
) (
    input  logic                      CLK,
    input  logic                      _RESET,
    input  logic [NUM_IN-1:0]         in_valid,
    output logic [NUM_IN-1:0]         in_ready,
    input  logic [NUM_IN*W-1:0]       in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [W-1:0]              out_data,
    output logic [$clog2(NUM_IN)-1:0] grant_idx,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int IW = $clog2(NUM_IN);

    if (NUM_IN < 2 || W < 2 || LOCK_TIMEOUT < 1) begin : g_bad_params
        $error("noc_out_arbiter: NUM_IN >= 2, W >= 2 and LOCK_TIMEOUT >= 1 are required");
    end

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t         state_q;
    logic [IW-1:0]  rr_q;
    logic [IW-1:0]  owner_q;
    logic [IW-1:0]  grant_q;
    logic           out_valid_q;
    logic [W-1:0]   out_data_q;

    logic           slot_free;
    logic           found;
    logic           xfer;
    logic [IW-1:0]  win;
    logic [W-1:0]   flit;

    function automatic logic [IW-1:0] laneAt(input logic [IW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % NUM_IN;
        return s[IW-1:0];
    endfunction

    // Winner search: the owner alone while locked, otherwise first valid lane from rr_q upward.
    always_comb begin
        found = 1'b0;
        win   = '0;
        if (state_q == LOCKED) begin
            win   = owner_q;
            found = in_valid[owner_q];
        end else begin
            for (int k = 0; k < NUM_IN; k++) begin
                if (!found && in_valid[laneAt(rr_q, k)]) begin
                    found = 1'b1;
                    win   = laneAt(rr_q, k);
                end
            end
        end
    end

    assign slot_free = !out_valid_q || out_ready;
    assign xfer      = found && slot_free && _RESET;
    assign flit      = in_data[win*W +: W];

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[win] = 1'b1;
        end
    end

`ifdef NOC_ARB_WATCHDOG_EN
    localparam int CW = $clog2(LOCK_TIMEOUT + 1);

    logic [CW-1:0] wd_q;
    logic          timeout_err_q;
    logic          wd_expire;

    assign wd_expire   = (state_q == LOCKED) && !xfer && (wd_q == CW'(LOCK_TIMEOUT - 1));
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge _RESET) begin
        if (!_RESET) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            owner_q       <= '0;
            grant_q       <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
`ifdef NOC_ARB_WATCHDOG_EN
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= flit;
                grant_q     <= win;
                if (flit[W-1]) begin
                    state_q <= IDLE;
                    rr_q    <= laneAt(win, 1);
                end else begin
                    state_q <= LOCKED;
                    owner_q <= win;
                end
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
`ifdef NOC_ARB_WATCHDOG_EN
            // A stalled owner loses the lock; its next flit is arbitrated as a fresh head.
            if (state_q == LOCKED && !xfer) begin
                if (wd_expire) begin
                    state_q       <= IDLE;
                    rr_q          <= laneAt(owner_q, 1);
                    timeout_err_q <= 1'b1;
                    wd_q          <= '0;
                end else begin
                    wd_q <= wd_q + 1'b1;
                end
            end else begin
                wd_q <= '0;
            end
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == LOCKED);

endmodule

// File: tb/tb_noc_out_arbiter.sv
// tb_noc_out_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic compared against a packet-level reference model.
module tb_noc_out_arbiter;

    localparam int TB_TIMEOUT = 8;

    logic        clock;
    logic        resetN;
    logic [3:0]  inValid;
    logic [3:0]  inReady;
    logic [35:0] inData;
    logic        outValid;
    logic        outReady;
    logic [8:0]  outData;
    logic [1:0]  grantIdx;
    logic        busy;
    logic        timeoutErr;

    int total = 0;
    int bad   = 0;

    noc_out_arbiter #(
        .NUM_IN(4),
        .W(9),
        .LOCK_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .CLK(clock),
        ._RESET(resetN),
        .in_valid(inValid),
        .in_ready(inReady),
        .in_data(inData),
        .out_valid(outValid),
        .out_ready(outReady),
        .out_data(outData),
        .grant_idx(grantIdx),
        .busy(busy),
        .timeout_err(timeoutErr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  v;
        logic [35:0] d;
        logic        ordy;
        logic [3:0]  expReady;
        logic        expOv;
        logic [8:0]  expOd;
        logic [1:0]  expGi;
        logic        expBusy;
    } vec_t;

    vec_t vecs[$];

    // Reference model: packet ownership and pointer kept as plain integers.
    bit         mLocked;
    int         mOwner;
    int         mPtr;
    bit         mOv;
    logic [8:0] mOd;
    int         mGi;
    bit         mTo;
    int         mWait;

    function automatic logic [35:0] pack(input logic [8:0] l0, input logic [8:0] l1,
                                         input logic [8:0] l2, input logic [8:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic addVec(input logic [3:0] v, input logic [35:0] d, input logic ordy,
                          input logic [3:0] er, input logic eov, input logic [8:0] eod,
                          input logic [1:0] egi, input logic ebusy);
        vec_t x;
        x.v = v; x.d = d; x.ordy = ordy;
        x.expReady = er; x.expOv = eov; x.expOd = eod; x.expGi = egi; x.expBusy = ebusy;
        vecs.push_back(x);
    endtask

    task automatic checkOutput(input string name, input logic [35:0] act, input logic [35:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, sample in_ready mid-cycle, return after the next edge.
    task automatic applyStimulus(input logic [3:0] v, input logic [35:0] d, input logic ordy,
                                 output logic [3:0] readySeen);
        inValid  = v;
        inData   = d;
        outReady = ordy;
        @(negedge clock);
        readySeen = inReady;
        @(posedge clock);
        #1;
    endtask

    task automatic modelReset();
        mLocked = 0; mOwner = 0; mPtr = 0; mOv = 0; mOd = '0; mGi = 0; mTo = 0; mWait = 0;
    endtask

    task automatic resetDut();
        resetN = 1'b0;
        @(posedge clock);
        #1;
        resetN = 1'b1;
        modelReset();
    endtask

    function automatic int pickLane(input logic [3:0] v, input logic ordy);
        if (mOv && !ordy) return -1;
        if (mLocked) return v[mOwner] ? mOwner : -1;
        for (int k = 0; k < 4; k++) begin
            if (v[(mPtr + k) % 4]) return (mPtr + k) % 4;
        end
        return -1;
    endfunction

    task automatic modelCycle(input logic [3:0] v, input logic [35:0] d, input logic ordy);
        int         g;
        bit         wasLocked;
        logic [8:0] f;
        logic [3:0] expReady;
        inValid  = v;
        inData   = d;
        outReady = ordy;
        @(negedge clock);
        g = pickLane(v, ordy);
        expReady = (g >= 0) ? (4'b0001 << g) : 4'b0000;
        checkOutput("model in_ready", inReady, expReady);
        checkOutput("model out_valid", outValid, mOv);
        checkOutput("model out_data", outData, mOd);
        checkOutput("model grant_idx", grantIdx, mGi);
        checkOutput("model busy", busy, mLocked);
        checkOutput("model timeout_err", timeoutErr, mTo);
        @(posedge clock);
        wasLocked = mLocked;
        if (g >= 0) begin
            f   = d[g*9 +: 9];
            mOv = 1; mOd = f; mGi = g;
            if (f[8]) begin
                mLocked = 0;
                mPtr    = (g + 1) % 4;
            end else begin
                mLocked = 1;
                mOwner  = g;
            end
        end else if (ordy) begin
            mOv = 0;
        end
`ifdef NOC_ARB_WATCHDOG_EN
        if (wasLocked && g < 0) begin
            mWait++;
            if (mWait == TB_TIMEOUT) begin
                mLocked = 0;
                mPtr    = (mOwner + 1) % 4;
                mTo     = 1;
                mWait   = 0;
            end
        end else begin
            mWait = 0;
        end
`else
        if (wasLocked) mWait = 0;
`endif
        #1;
    endtask

    initial begin
        logic [3:0]  rdy;
        logic [35:0] rr;
        logic [63:0] rnd;

        rr = pack(9'h100, 9'h101, 9'h102, 9'h103);

        // Reset with every lane requesting: nothing may be accepted.
        resetN   = 1'b0;
        inValid  = 4'b1111;
        inData   = rr;
        outReady = 1'b1;
        #2;
        checkOutput("reset in_ready", inReady, 4'b0000);
        checkOutput("reset out_valid", outValid, 1'b0);
        checkOutput("reset out_data", outData, 9'h000);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset grant_idx", grantIdx, 2'd0);
        checkOutput("reset timeout_err", timeoutErr, 1'b0);
        @(posedge clock);
        #1;
        resetN = 1'b1;

        addVec(4'b1111, rr, 1, 4'b0001, 1, 9'h100, 2'd0, 0);
        addVec(4'b1111, rr, 1, 4'b0010, 1, 9'h101, 2'd1, 0);
        addVec(4'b1111, rr, 1, 4'b0100, 1, 9'h102, 2'd2, 0);
        addVec(4'b1111, rr, 1, 4'b1000, 1, 9'h103, 2'd3, 0);
        addVec(4'b1111, rr, 1, 4'b0001, 1, 9'h100, 2'd0, 0);
        addVec(4'b1111, rr, 1, 4'b0010, 1, 9'h101, 2'd1, 0);
        addVec(4'b0001, pack(9'h1EE, 9'h0, 9'h0, 9'h0), 1, 4'b0001, 1, 9'h1EE, 2'd0, 0);
        addVec(4'b0110, pack(9'h0, 9'h0AA, 9'h1DD, 9'h0), 1, 4'b0010, 1, 9'h0AA, 2'd1, 1);
        addVec(4'b0110, pack(9'h0, 9'h0BB, 9'h1DD, 9'h0), 1, 4'b0010, 1, 9'h0BB, 2'd1, 1);
        addVec(4'b0110, pack(9'h0, 9'h1CC, 9'h1DD, 9'h0), 1, 4'b0010, 1, 9'h1CC, 2'd1, 0);
        addVec(4'b0100, pack(9'h0, 9'h0, 9'h1DD, 9'h0), 1, 4'b0100, 1, 9'h1DD, 2'd2, 0);
        addVec(4'b0001, pack(9'h0AA, 9'h0, 9'h0, 9'h0), 1, 4'b0001, 1, 9'h0AA, 2'd0, 1);
        for (int i = 0; i < 5; i++) begin
            addVec(4'b0011, pack(9'h0BB, 9'h1CC, 9'h0, 9'h0), 0, 4'b0000, 1, 9'h0AA, 2'd0, 1);
        end
        addVec(4'b0011, pack(9'h0BB, 9'h1CC, 9'h0, 9'h0), 1, 4'b0001, 1, 9'h0BB, 2'd0, 1);
        addVec(4'b0011, pack(9'h1FF, 9'h1CC, 9'h0, 9'h0), 1, 4'b0001, 1, 9'h1FF, 2'd0, 0);
        addVec(4'b0010, pack(9'h0, 9'h1CC, 9'h0, 9'h0), 1, 4'b0010, 1, 9'h1CC, 2'd1, 0);
        addVec(4'b0000, pack(9'h0, 9'h0, 9'h0, 9'h0), 1, 4'b0000, 0, 9'h1CC, 2'd1, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].v, vecs[i].d, vecs[i].ordy, rdy);
            checkOutput($sformatf("vec%0d in_ready", i), rdy, vecs[i].expReady);
            checkOutput($sformatf("vec%0d out_valid", i), outValid, vecs[i].expOv);
            checkOutput($sformatf("vec%0d out_data", i), outData, vecs[i].expOd);
            checkOutput($sformatf("vec%0d grant_idx", i), grantIdx, vecs[i].expGi);
            checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].expBusy);
        end

        // Reset pulled mid-packet, away from any clock edge.
        applyStimulus(4'b0100, pack(9'h0, 9'h0, 9'h033, 9'h0), 1, rdy);
        checkOutput("midrst head accepted", rdy, 4'b0100);
        checkOutput("midrst busy before", busy, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midrst in_ready", inReady, 4'b0000);
        checkOutput("midrst out_valid", outValid, 1'b0);
        checkOutput("midrst out_data", outData, 9'h000);
        checkOutput("midrst busy", busy, 1'b0);
        checkOutput("midrst grant_idx", grantIdx, 2'd0);
        @(posedge clock);
        #1;
        resetN = 1'b1;
        modelReset();
        modelCycle(4'b0101, pack(9'h1A0, 9'h0, 9'h1B0, 9'h0), 1);
        checkOutput("midrst fresh grant", grantIdx, 2'd0);
        checkOutput("midrst fresh data", outData, 9'h1A0);

        // Stalled owner: watchdog releases the lock, or the lock is held forever.
        resetDut();
        applyStimulus(4'b1001, pack(9'h011, 9'h0, 9'h0, 9'h1F3), 1, rdy);
        checkOutput("wd head grant", rdy, 4'b0001);
        checkOutput("wd head busy", busy, 1'b1);
`ifdef NOC_ARB_WATCHDOG_EN
        for (int i = 1; i <= TB_TIMEOUT; i++) begin
            applyStimulus(4'b1000, pack(9'h0, 9'h0, 9'h0, 9'h1F3), 1, rdy);
            checkOutput($sformatf("wd wait%0d in_ready", i), rdy, 4'b0000);
            if (i < TB_TIMEOUT) begin
                checkOutput($sformatf("wd wait%0d busy", i), busy, 1'b1);
            end else begin
                checkOutput("wd expired busy", busy, 1'b0);
                checkOutput("wd expired timeout_err", timeoutErr, 1'b1);
            end
        end
        applyStimulus(4'b1000, pack(9'h0, 9'h0, 9'h0, 9'h1F3), 1, rdy);
        checkOutput("wd next in_ready", rdy, 4'b1000);
        checkOutput("wd next grant_idx", grantIdx, 2'd3);
        checkOutput("wd next out_data", outData, 9'h1F3);
        checkOutput("wd sticky timeout_err", timeoutErr, 1'b1);
`else
        for (int i = 0; i < 100; i++) begin
            applyStimulus(4'b1000, pack(9'h0, 9'h0, 9'h0, 9'h1F3), 1, rdy);
            if (rdy != 4'b0000) begin
                checkOutput($sformatf("lock hold cycle%0d in_ready", i), rdy, 4'b0000);
            end
        end
        checkOutput("lock hold busy", busy, 1'b1);
        checkOutput("lock hold timeout_err", timeoutErr, 1'b0);
        checkOutput("lock hold out_valid", outValid, 1'b0);
        applyStimulus(4'b1001, pack(9'h1F0, 9'h0, 9'h0, 9'h1F3), 1, rdy);
        checkOutput("lock release in_ready", rdy, 4'b0001);
        checkOutput("lock release busy", busy, 1'b0);
`endif

        // Randomized traffic against the reference model.
        resetDut();
        for (int i = 0; i < 600; i++) begin
            rnd = {$urandom, $urandom};
            modelCycle(4'($urandom_range(0, 15)), rnd[35:0], ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
